// File: rtl/prv_trap_pkg.sv
// Shared types and the exception-bit to cause mapping for the trap collector.
// The record widths set the default XLEN/CAUSE_W/lane width of prv_trap_collector.
package prv_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } trap_state_t;

    localparam int EXC_BREAKPOINT  = 0;
    localparam int EXC_INSN_PAGE   = 1;
    localparam int EXC_INSN_FAULT  = 2;
    localparam int EXC_ILLEGAL     = 3;
    localparam int EXC_MAL_INSN    = 4;
    localparam int EXC_ENV         = 5;
    localparam int EXC_MAL_LOAD    = 6;
    localparam int EXC_MAL_STORE   = 7;
    localparam int EXC_LOAD_PAGE   = 8;
    localparam int EXC_STORE_PAGE  = 9;
    localparam int EXC_LOAD_FAULT  = 10;
    localparam int EXC_STORE_FAULT = 11;

    localparam int TRAP_XLEN    = 32;
    localparam int TRAP_CAUSE_W = 5;
    localparam int TRAP_LANE_W  = 1;

    typedef struct packed {
        logic                    is_intr;
        logic [TRAP_CAUSE_W-1:0] cause;
        logic [TRAP_XLEN-1:0]    epc;
        logic [TRAP_XLEN-1:0]    badaddr;
        logic [TRAP_LANE_W-1:0]  lane;
    } trap_rec_t;

    // Bits past the standard set fall into the custom cause range starting at 24.
    function automatic logic [7:0] exc_cause(input int unsigned idx, input logic [1:0] priv);
        case (idx)
            EXC_BREAKPOINT:  exc_cause = 8'd3;
            EXC_INSN_PAGE:   exc_cause = 8'd12;
            EXC_INSN_FAULT:  exc_cause = 8'd1;
            EXC_ILLEGAL:     exc_cause = 8'd2;
            EXC_MAL_INSN:    exc_cause = 8'd0;
            EXC_ENV:         exc_cause = 8'd8 + {6'd0, priv};
            EXC_MAL_LOAD:    exc_cause = 8'd4;
            EXC_MAL_STORE:   exc_cause = 8'd6;
            EXC_LOAD_PAGE:   exc_cause = 8'd13;
            EXC_STORE_PAGE:  exc_cause = 8'd15;
            EXC_LOAD_FAULT:  exc_cause = 8'd5;
            EXC_STORE_FAULT: exc_cause = 8'd7;
            default:         exc_cause = 8'(idx + 32'd12);
        endcase
    endfunction

endpackage

// File: rtl/prv_lane_prio_enc.sv
// Lowest-set-bit priority encoder; bit 0 wins.
module prv_lane_prio_enc #(
    parameter int WIDTH = 2,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] bits,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |bits;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/prv_trap_collector.sv
// Multi-lane trap collector: picks the oldest trapping lane (or an interrupt),
// latches the trap, hands it to the priv block and holds pipe_clear until redirect.
//
// state    | meaning
// ST_IDLE  | scanning lanes, commit_mask gates younger lanes behind a trap
// ST_HOLD  | trap latched and presented, waiting for trap_ready
// ST_FLUSH | trap accepted, pipe_clear high until redirect_valid
module prv_trap_collector
    import prv_trap_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = TRAP_XLEN,
    parameter int EXC_W     = 12,
    parameter int CAUSE_W   = TRAP_CAUSE_W,
    parameter int CNT_W     = 16,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [NUM_LANES-1:0]              lane_valid,
    input  logic [NUM_LANES-1:0][EXC_W-1:0]   lane_exc,
    input  logic [NUM_LANES-1:0][XLEN-1:0]    lane_pc,
    input  logic [NUM_LANES-1:0][XLEN-1:0]    lane_badaddr,
    input  logic [1:0]                        curr_privilege_level,
    input  logic                              intr_req,
    input  logic [CAUSE_W-1:0]                intr_cause,
    input  logic                              trap_ready,
    input  logic                              redirect_valid,
    output logic                              trap_valid,
    output logic                              trap_is_intr,
    output logic [CAUSE_W-1:0]                trap_cause,
    output logic [XLEN-1:0]                   trap_epc,
    output logic [XLEN-1:0]                   trap_badaddr,
    output logic [LANE_W-1:0]                 trap_lane,
    output logic [NUM_LANES-1:0]              commit_mask,
    output logic                              pipe_clear,
    output logic                              busy,
    output logic [CNT_W-1:0]                  trap_count
);

    localparam int EXC_IDX_W = (EXC_W > 1) ? $clog2(EXC_W) : 1;

    trap_state_t            state_q, state_d;
    trap_rec_t              rec_q, rec_d;
    logic [NUM_LANES-1:0]   lane_trap;
    logic [NUM_LANES-1:0]   older_mask;
    logic [LANE_W-1:0]      sel_lane;
    logic                   any_lane_trap;
    logic [EXC_W-1:0]       sel_exc;
    logic [EXC_IDX_W-1:0]   exc_idx;
    logic                   exc_any;
    logic [7:0]             exc_cause_full;
    logic                   take_intr;
    logic                   accept;

    always_comb begin
        lane_trap  = '0;
        older_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_trap[i]  = lane_valid[i] & (|lane_exc[i]);
            older_mask[i] = LANE_W'(i) < sel_lane;
        end
    end

    prv_lane_prio_enc #(.WIDTH(NUM_LANES), .IDX_W(LANE_W)) u_lane_enc (
        .bits (lane_trap),
        .idx  (sel_lane),
        .any  (any_lane_trap)
    );

    assign sel_exc = lane_exc[sel_lane];

    prv_lane_prio_enc #(.WIDTH(EXC_W), .IDX_W(EXC_IDX_W)) u_exc_enc (
        .bits (sel_exc),
        .idx  (exc_idx),
        .any  (exc_any)
    );

    assign exc_cause_full = exc_cause(32'(exc_idx), curr_privilege_level);
    assign take_intr      = intr_req & lane_valid[0];

    always_comb begin
        state_d     = state_q;
        rec_d       = rec_q;
        commit_mask = '0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take_intr) begin
                    commit_mask   = '0;
                    rec_d.is_intr = 1'b1;
                    rec_d.cause   = TRAP_CAUSE_W'(intr_cause);
                    rec_d.epc     = TRAP_XLEN'(lane_pc[0]);
                    rec_d.badaddr = '0;
                    rec_d.lane    = '0;
                    state_d       = ST_HOLD;
                end else if (any_lane_trap && exc_any) begin
                    commit_mask   = lane_valid & older_mask;
                    rec_d.is_intr = 1'b0;
                    rec_d.cause   = TRAP_CAUSE_W'(exc_cause_full);
                    rec_d.epc     = TRAP_XLEN'(lane_pc[sel_lane]);
                    rec_d.badaddr = TRAP_XLEN'(lane_badaddr[sel_lane]);
                    rec_d.lane    = TRAP_LANE_W'(sel_lane);
                    state_d       = ST_HOLD;
                end else begin
                    commit_mask = lane_valid;
                end
            end
            ST_HOLD: begin
                if (trap_valid && trap_ready) begin
                    accept  = 1'b1;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (redirect_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            rec_q      <= '0;
            trap_valid <= 1'b0;
            pipe_clear <= 1'b0;
            busy       <= 1'b0;
            trap_count <= '0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            trap_valid <= (state_d == ST_HOLD);
            pipe_clear <= (state_d == ST_FLUSH);
            busy       <= (state_d != ST_IDLE);
            if (accept && (trap_count != {CNT_W{1'b1}}))
                trap_count <= trap_count + 1'b1;
        end
    end

    assign trap_is_intr = rec_q.is_intr;
    assign trap_cause   = CAUSE_W'(rec_q.cause);
    assign trap_epc     = XLEN'(rec_q.epc);
    assign trap_badaddr = XLEN'(rec_q.badaddr);
    assign trap_lane    = LANE_W'(rec_q.lane);

endmodule

// File: doc/prv_trap_collector.md
# prv_trap_collector

Parametrised trap collector between an N-lane commit stage and the privilege block. Each cycle it scans per-lane exception vectors plus one pending-interrupt request, selects the oldest trapping lane and its highest-priority cause, and latches cause/EPC/badaddr. It presents the latched trap to the priv block over a valid/ready handshake, then holds `pipe_clear` until the PC redirect is acknowledged. It generalises the single-lane hazard-to-priv exception path to `NUM_LANES` lanes, adds backpressure, and adds a taken-trap counter.

## Interface
- `NUM_LANES`, 2, commit lanes; lane 0 is oldest
- `XLEN`, 32, PC/address width
- `EXC_W`, 12, exception bits per lane; bit index is priority, bit 0 highest
- `CAUSE_W`, 5, cause field width
- `CNT_W`, 16, trap counter width
- `CLK` in 1, clock
- `nRST` in 1, synchronous active-low reset
- `lane_valid` in NUM_LANES, lane holds a committing instruction
- `lane_exc` in NUM_LANES×EXC_W, exception bits per lane
- `lane_pc` in NUM_LANES×XLEN, lane instruction PC
- `lane_badaddr` in NUM_LANES×XLEN, faulting address/value per lane
- `curr_privilege_level` in 2, used for the env-call cause
- `intr_req` in 1, enabled interrupt pending
- `intr_cause` in CAUSE_W, interrupt cause code
- `trap_ready` in 1, priv block accepts the trap
- `redirect_valid` in 1, priv block is driving `insert_pc` this cycle
- `trap_valid` out 1, latched trap presented
- `trap_is_intr` out 1, trap is an interrupt
- `trap_cause` out CAUSE_W, mcause code
- `trap_epc` out XLEN, EPC
- `trap_badaddr` out XLEN, tval
- `trap_lane` out $clog2(NUM_LANES), lane that trapped
- `commit_mask` out NUM_LANES, lanes allowed to commit this cycle
- `pipe_clear` out 1, flush the pipeline
- `busy` out 1, state ≠ IDLE
- `trap_count` out CNT_W, saturating count of accepted traps

## Operation
- FSM states: IDLE, HOLD, FLUSH.
- IDLE, detection:
  - A lane is trapping if `lane_valid[i] && |lane_exc[i]`.
  - An interrupt is taken if `intr_req && lane_valid[0]`. It wins over all exceptions: EPC is `lane_pc[0]`, badaddr is 0, `commit_mask` is 0.
  - Otherwise the lowest-index trapping lane `k` is selected. The lowest set bit of `lane_exc[k]` is mapped to a cause by the package function. `commit_mask = lane_valid & ((1<<k)-1)`.
  - With no trap, `commit_mask = lane_valid`.
  - On a trap, latch the trap fields and go to HOLD.
- Exception bit→cause mapping: 0 breakpoint→3, 1 insn page→12, 2 insn fault→1, 3 illegal→2, 4 mal insn→0, 5 env→8+`curr_privilege_level`, 6 mal load→4, 7 mal store→6, 8 load page→13, 9 store page→15, 10 load fault→5, 11 store fault→7. Bits ≥12, if present, map to cause 24+(bit−12), truncated to CAUSE_W.
- HOLD:
  - `trap_valid`=1; fields stable; lane inputs ignored; `commit_mask`=0.
  - `trap_valid && trap_ready` → FLUSH, and `trap_count` increments, saturating at all-ones.
- FLUSH: `pipe_clear`=1, `commit_mask`=0. `redirect_valid` → IDLE.
- `busy`=1 in HOLD and FLUSH.

## Timing
- Reset values: state IDLE; `trap_valid`, `trap_is_intr`, `pipe_clear`, `busy` = 0; `trap_cause`, `trap_epc`, `trap_badaddr`, `trap_lane`, `trap_count` = 0. `commit_mask` follows `lane_valid` combinationally after reset.
- `commit_mask` is combinational from inputs in IDLE only. All other outputs are registered.
- Latency: trap detected in cycle t → `trap_valid` high in t+1.
- `trap_ready` is sampled only while `trap_valid`=1. `trap_ready` held high before a trap gives acceptance in t+1, FLUSH in t+2.
- FLUSH lasts at least 1 cycle. `redirect_valid` is sampled only in FLUSH; its assertion in HOLD is ignored.
- A trap is never accepted in FLUSH. A new trap can be detected in the first IDLE cycle after FLUSH.
- `nRST` low at any edge returns to IDLE and reset values next cycle, discarding a pending trap. `trap_count` clears.
- `intr_req` falling during HOLD does not withdraw the latched interrupt.

## Structure
- Package `prv_trap_pkg` holds:
  - state enum `trap_state_t`
  - exception bit index localparams
  - `exc_cause(idx, priv)` function
  - `trap_rec_t` struct (is_intr, cause, epc, badaddr, lane)
- Sub-module `prv_lane_prio_enc` (parameter WIDTH): lowest-set-bit index plus any-set flag. Instantiated once across lanes and once across the selected lane's exception bits.

## Test plan
- NUM_LANES=2. Lane0 valid with no exception; lane1 valid with `lane_exc`=bit3, pc=0x100 → `commit_mask`=01; next cycle `trap_valid`=1, cause=2, epc=0x100, `trap_lane`=1.
- Lane0 `lane_exc`=bits 6 and 10, badaddr=0x2003, priv=M → cause=4, badaddr=0x2003. Env-only in U mode → cause=8; in M mode → cause=11.
- `intr_req`=1, `intr_cause`=7, together with lane0 exception → `trap_is_intr`=1, epc=`lane_pc[0]`, `commit_mask`=00.
- `trap_ready` low for 5 cycles → `trap_valid` and fields stable and new lane traps ignored. Ready high → FLUSH with `pipe_clear`=1 until `redirect_valid`, and `trap_count` +1.
- `nRST` low during FLUSH → next cycle IDLE, `pipe_clear`=0, `trap_count`=0.
- CNT_W=2: accept 5 traps → `trap_count` saturates at 3.
